e203_itcm_ram_ctrl: RTL and testbench
=====================================

Name: e203_itcm_ram_ctrl

Overview:
Controller in front of the ITCM RAM macro wrapper. It shares the single-port RAM between the IFU fetch port (read-only) and the LSU port (read/write with byte mask) using round-robin arbitration. It absorbs the macro's 1-cycle read latency with per-port response buffering. It also drives RAM light-sleep entry and exit from an idle counter.

Parameters:
AW, 13, RAM word-address width
DW, 64, RAM data width
MW, 8, write-enable mask width (DW/8)
LS_IDLE_CYC, 16, consecutive idle cycles before light-sleep entry (must be >= 1)
LS_CW, 5, idle counter width (must satisfy 2^LS_CW > LS_IDLE_CYC)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ls_en  in  1  light-sleep enable
ifu_cmd_valid / ifu_cmd_ready  in/out  1  IFU command handshake
ifu_cmd_addr  in  AW  IFU word address
ifu_rsp_valid / ifu_rsp_ready  out/in  1  IFU response handshake
ifu_rsp_rdata  out  DW  IFU read data
lsu_cmd_valid / lsu_cmd_ready  in/out  1  LSU command handshake
lsu_cmd_read  in  1  1 = read, 0 = write
lsu_cmd_addr  in  AW  LSU word address
lsu_cmd_wdata  in  DW  write data
lsu_cmd_wmask  in  MW  byte write mask
lsu_rsp_valid / lsu_rsp_ready  out/in  1  LSU response handshake
lsu_rsp_rdata  out  DW  read data; 0 for writes
ram_cs, ram_we  out  1  RAM chip select, write enable
ram_addr  out  AW  RAM address
ram_wem  out  MW  RAM write mask
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data, valid the cycle after ram_cs
ram_sd, ram_ds, ram_ls  out  1  shutdown, deep sleep, light sleep
itcm_active  out  1  high whenever the controller is not in SLEEP

Behaviour:
- Reset values: all *_ready, *_rsp_valid, ram_cs, ram_we, ram_ls = 0; ram_sd and ram_ds are constant 0; itcm_active = 1; round-robin pointer points to LSU (LSU wins the first tie); idle counter = 0; FSM = ACTIVE.
- Port busy: busy_x = held_x | (inflight_x & ~x_rsp_ready).
  - inflight_x: port x issued a RAM access in the previous cycle.
  - held_x: port x holds a buffered, unaccepted response.
- Eligibility: a port is eligible when cmd_valid = 1, busy = 0 and FSM = ACTIVE.
- Arbitration:
  - One eligible port: it is granted.
  - Both eligible: the port not granted last wins.
  - Grant is combinational; cmd_ready = grant.
- Handshake and RAM drive:
  - A handshake (valid & ready) drives ram_cs = 1 the same cycle, with ram_addr, ram_we (LSU write only), ram_wem (wmask; all-zero for reads), ram_din.
  - With no handshake, ram_cs = 0 and the other RAM outputs hold their previous values (no toggling when idle).
- Response timing:
  - A command accepted in cycle N gives rsp_valid = 1 in cycle N+1.
  - Read rdata = ram_dout (bypass); write rdata = 0.
  - If rsp_ready = 0 in N+1, rdata is captured into the port's holding register and set_held.
  - Held data is presented until rsp_ready, then held clears.
  - The IFU and LSU response paths are independent; there is no cross-port ordering.
  - Throughput: one access per cycle total; back-to-back accesses on one port are allowed while its rsp_ready = 1.
- Low-power FSM (ACTIVE, SLEEP, WAKE):
  - ACTIVE: idle counter increments each cycle with ram_cs = 0 and resets to 0 on ram_cs = 1. It saturates at LS_IDLE_CYC.
  - ACTIVE -> SLEEP when the counter = LS_IDLE_CYC, ls_en = 1, no held/inflight response and no cmd_valid. ram_ls = 1 from the next cycle.
  - SLEEP: ram_ls = 1, all cmd_ready = 0, itcm_active = 0. Any cmd_valid moves to WAKE next cycle.
  - WAKE: ram_ls = 0, cmd_ready = 0 for exactly 1 cycle, then ACTIVE with counter = 0.
  - ls_en deasserted during SLEEP: go to WAKE.
  - Simultaneous cmd_valid and idle threshold: stay in ACTIVE and serve the command.
- Reset mid-transaction: all held responses and inflight flags are discarded; no response is issued after reset.

Decomposition:
- Shared e203 defines file supplies E203_ITCM_RAM_AW/DW/MW for the top-level instance overrides.
- Shared package constants: state encodings ACTIVE = 2'd0, SLEEP = 2'd1, WAKE = 2'd2.
- One sub-module, e203_itcm_rsp_buf: per-port inflight/held flags, holding register and rdata mux. Instantiated twice.

Test Plan:
1. Reset, then IFU read of addr 0x010 (RAM returns 0xDEADBEEF_00000001) with rsp_ready = 1 -> ram_cs in cycle N, ifu_rsp_valid in N+1 with that data.
2. Both ports valid for 4 cycles, both rsp_ready = 1 -> grants alternate LSU, IFU, LSU, IFU; ram_cs high all 4 cycles.
3. LSU write addr 0x020, wdata 0x1122334455667788, wmask 0x0F -> ram_we = 1, ram_wem = 0x0F; rsp next cycle with rdata 0.
4. LSU read with lsu_rsp_ready held 0 for 3 cycles while ram_dout changes -> original data held stable; lsu_cmd_ready = 0 until acceptance; IFU traffic unaffected.
5. ls_en = 1, idle 16 cycles -> ram_ls = 1, itcm_active = 0; IFU cmd_valid -> 1 WAKE cycle with ready = 0, ram_ls = 0, grant on the following cycle.
6. rst_n pulsed low while an LSU response is held -> all rsp_valid = 0 after reset; no stale response delivered.

Source files
------------

// File: rtl/e203_itcm_ram_ctrl_pkg.sv
// ============================================================================
// e203_itcm_ram_ctrl_pkg : shared types for the ITCM RAM controller
// Rev 1.0
// ============================================================================
`default_nettype none

package e203_itcm_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } lp_state_t;

endpackage

`default_nettype wire

// File: rtl/e203_itcm_rsp_buf.sv
// ============================================================================
// e203_itcm_rsp_buf : per-port response path (RAM bypass + holding register)
// Rev 1.0
// ============================================================================
`default_nettype none

module e203_itcm_rsp_buf #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic          issue_read,
  input  logic [DW-1:0] ram_dout,
  input  logic          rsp_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy
);

  logic          inflight;
  logic          inflight_rd;
  logic          held;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] live_data;

  // inflight and held are mutually exclusive: a port cannot issue while busy
  assign live_data = inflight_rd ? ram_dout : '0;
  assign rsp_valid = inflight | held;
  assign rsp_rdata = held ? hold_data : live_data;
  assign busy      = held | (inflight & ~rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_rd <= 1'b0;
      held        <= 1'b0;
      hold_data   <= '0;
    end else begin
      inflight    <= issue;
      inflight_rd <= issue & issue_read;
      if (inflight & ~rsp_ready) begin
        held      <= 1'b1;
        hold_data <= live_data;
      end else if (held & rsp_ready) begin
        held      <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/e203_itcm_ram_ctrl.sv
// ============================================================================
// e203_itcm_ram_ctrl : IFU/LSU round-robin ITCM RAM controller with light sleep
// Rev 1.0
// ============================================================================
`default_nettype none

module e203_itcm_ram_ctrl
  import e203_itcm_ram_ctrl_pkg::*;
#(
  parameter int AW          = 13,
  parameter int DW          = 64,
  parameter int MW          = 8,
  parameter int LS_IDLE_CYC = 16,
  parameter int LS_CW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ls_en,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic          lsu_cmd_read,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic [DW-1:0] lsu_cmd_wdata,
  input  logic [MW-1:0] lsu_cmd_wmask,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls,
  output logic          itcm_active
);

  lp_state_t        state;
  logic [LS_CW-1:0] idle_cnt;
  logic             last_ifu;
  logic             ifu_busy, lsu_busy;
  logic             ifu_elig, lsu_elig;
  logic             ifu_grant, lsu_grant, any_grant, lsu_wr;
  logic             idle_thr, sleep_ok;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic [MW-1:0]    wem_q;
  logic [DW-1:0]    din_q;

  assign ifu_elig  = ifu_cmd_valid & ~ifu_busy & (state == ST_ACTIVE);
  assign lsu_elig  = lsu_cmd_valid & ~lsu_busy & (state == ST_ACTIVE);
  // last_ifu = 1 means IFU won last time, so LSU takes the next tie
  assign lsu_grant = lsu_elig & (~ifu_elig | last_ifu);
  assign ifu_grant = ifu_elig & ~lsu_grant;
  assign any_grant = ifu_grant | lsu_grant;
  assign lsu_wr    = lsu_grant & ~lsu_cmd_read;

  assign ifu_cmd_ready = ifu_grant;
  assign lsu_cmd_ready = lsu_grant;

  // RAM pins keep their last values while idle to avoid needless toggling
  assign ram_cs   = any_grant;
  assign ram_addr = ifu_grant ? ifu_cmd_addr : (lsu_grant ? lsu_cmd_addr : addr_q);
  assign ram_we   = any_grant ? lsu_wr : we_q;
  assign ram_wem  = any_grant ? (lsu_wr ? lsu_cmd_wmask : '0) : wem_q;
  assign ram_din  = lsu_grant ? lsu_cmd_wdata : din_q;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wem_q    <= '0;
      din_q    <= '0;
      last_ifu <= 1'b1;
    end else if (any_grant) begin
      addr_q   <= ram_addr;
      we_q     <= ram_we;
      wem_q    <= ram_wem;
      din_q    <= ram_din;
      last_ifu <= ifu_grant;
    end
  end

  e203_itcm_rsp_buf #(.DW(DW)) u_ifu_rsp (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (ifu_grant),
    .issue_read (1'b1),
    .ram_dout   (ram_dout),
    .rsp_ready  (ifu_rsp_ready),
    .rsp_valid  (ifu_rsp_valid),
    .rsp_rdata  (ifu_rsp_rdata),
    .busy       (ifu_busy)
  );

  e203_itcm_rsp_buf #(.DW(DW)) u_lsu_rsp (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (lsu_grant),
    .issue_read (lsu_cmd_read),
    .ram_dout   (ram_dout),
    .rsp_ready  (lsu_rsp_ready),
    .rsp_valid  (lsu_rsp_valid),
    .rsp_rdata  (lsu_rsp_rdata),
    .busy       (lsu_busy)
  );

  assign idle_thr = (idle_cnt == LS_CW'(LS_IDLE_CYC));
  assign sleep_ok = idle_thr & ls_en & ~ifu_rsp_valid & ~lsu_rsp_valid
                  & ~ifu_cmd_valid & ~lsu_cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACTIVE;
      idle_cnt    <= '0;
      ram_ls      <= 1'b0;
      itcm_active <= 1'b1;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (sleep_ok) begin
            state       <= ST_SLEEP;
            ram_ls      <= 1'b1;
            itcm_active <= 1'b0;
          end else if (any_grant) begin
            idle_cnt <= '0;
          end else if (!idle_thr) begin
            idle_cnt <= idle_cnt + LS_CW'(1);
          end
        end
        ST_SLEEP: begin
          if (ifu_cmd_valid | lsu_cmd_valid | ~ls_en) begin
            state       <= ST_WAKE;
            ram_ls      <= 1'b0;
            itcm_active <= 1'b1;
          end
        end
        ST_WAKE: begin
          state    <= ST_ACTIVE;
          idle_cnt <= '0;
        end
        default: begin
          state       <= ST_ACTIVE;
          idle_cnt    <= '0;
          ram_ls      <= 1'b0;
          itcm_active <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_e203_itcm_ram_ctrl.sv
// ============================================================================
// tb_e203_itcm_ram_ctrl : randomized + directed bench with behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_e203_itcm_ram_ctrl;

  localparam int AW   = 13;
  localparam int DW   = 64;
  localparam int MW   = 8;
  localparam int IDLE = 16;

  logic          clk, rst_n, ls_en;
  logic          ifu_cmd_valid, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read, lsu_rsp_valid, lsu_rsp_ready;
  logic [AW-1:0] lsu_cmd_addr;
  logic [DW-1:0] lsu_cmd_wdata, lsu_rsp_rdata;
  logic [MW-1:0] lsu_cmd_wmask;
  logic          ram_cs, ram_we, ram_sd, ram_ds, ram_ls, itcm_active;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;

  e203_itcm_ram_ctrl #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE_CYC(IDLE), .LS_CW(5)) dut (
    .clk(clk), .rst_n(rst_n), .ls_en(ls_en),
    .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls),
    .itcm_active(itcm_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) o[b*8 +: 8] = n[b*8 +: 8];
    return o;
  endfunction

  // RAM macro stand-in: 1-cycle read latency, garbage on cycles without a read
  logic [63:0] env_mem   [0:8191];
  logic [63:0] model_mem [0:8191];

  always @(posedge clk) begin
    if (ram_cs && !ram_we) ram_dout <= env_mem[ram_addr];
    else                   ram_dout <= {$urandom, $urandom};
    if (ram_cs && ram_we)  env_mem[ram_addr] <= merge(env_mem[ram_addr], ram_din, ram_wem);
  end

  // Behavioural model: state 0 = serving, 1 = sleeping, 2 = waking
  int            m_state, m_idle;
  logic          m_last_ifu;
  logic [1:0]    m_pend, m_fresh;
  logic [63:0]   m_data [2];
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [MW-1:0] m_wem;
  logic [DW-1:0] m_din;
  logic [1:0]    v, rdy, busy, elig, gnt;
  logic          go_sleep;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_idle = 0; m_last_ifu = 1'b1; m_pend = '0; m_fresh = '0;
      m_addr = '0; m_we = 1'b0; m_wem = '0; m_din = '0;
      chk("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'h0);
      chk("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'h0);
      chk("rst_ram_ls", 64'(ram_ls), 64'h0);
      chk("rst_itcm_active", 64'(itcm_active), 64'h1);
    end else begin
      v   = {lsu_cmd_valid, ifu_cmd_valid};
      rdy = {lsu_rsp_ready, ifu_rsp_ready};
      for (int p = 0; p < 2; p++) begin
        busy[p] = m_pend[p] && !(m_fresh[p] && rdy[p]);
        elig[p] = v[p] && !busy[p] && (m_state == 0);
      end
      if (elig == 2'b11) gnt = m_last_ifu ? 2'b10 : 2'b01;
      else               gnt = elig;

      if (gnt[0]) begin
        m_addr = ifu_cmd_addr; m_we = 1'b0; m_wem = '0;
      end else if (gnt[1]) begin
        m_addr = lsu_cmd_addr; m_we = !lsu_cmd_read;
        m_wem  = lsu_cmd_read ? '0 : lsu_cmd_wmask;
        m_din  = lsu_cmd_wdata;
      end

      chk("ifu_cmd_ready", 64'(ifu_cmd_ready), 64'(gnt[0]));
      chk("lsu_cmd_ready", 64'(lsu_cmd_ready), 64'(gnt[1]));
      chk("ram_cs", 64'(ram_cs), 64'(gnt != 2'b00));
      chk("ram_addr", 64'(ram_addr), 64'(m_addr));
      chk("ram_we", 64'(ram_we), 64'(m_we));
      chk("ram_wem", 64'(ram_wem), 64'(m_wem));
      if (gnt[1] && !lsu_cmd_read) chk("ram_din", ram_din, m_din);
      chk("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(m_pend[0]));
      chk("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(m_pend[1]));
      if (m_pend[0]) chk("ifu_rsp_rdata", ifu_rsp_rdata, m_data[0]);
      if (m_pend[1]) chk("lsu_rsp_rdata", lsu_rsp_rdata, m_data[1]);
      chk("ram_ls", 64'(ram_ls), 64'(m_state == 1));
      chk("itcm_active", 64'(itcm_active), 64'(m_state != 1));
      chk("ram_sd_ds", 64'({ram_sd, ram_ds}), 64'h0);

      // low-power sequencing uses the pre-cycle pending state
      go_sleep = (m_idle >= IDLE) && ls_en && (m_pend == 2'b00) && (v == 2'b00);
      case (m_state)
        0: if (go_sleep) m_state = 1;
           else if (gnt != 2'b00) m_idle = 0;
           else if (m_idle < IDLE) m_idle = m_idle + 1;
        1: if ((v != 2'b00) || !ls_en) m_state = 2;
        default: begin m_state = 0; m_idle = 0; end
      endcase

      for (int p = 0; p < 2; p++) begin
        if (m_pend[p] && rdy[p]) m_pend[p] = 1'b0;
        m_fresh[p] = 1'b0;
      end
      if (gnt[0]) begin
        m_pend[0] = 1'b1; m_fresh[0] = 1'b1; m_data[0] = model_mem[ifu_cmd_addr];
      end
      if (gnt[1]) begin
        m_pend[1] = 1'b1; m_fresh[1] = 1'b1;
        m_data[1] = lsu_cmd_read ? model_mem[lsu_cmd_addr] : 64'h0;
        if (!lsu_cmd_read)
          model_mem[lsu_cmd_addr] = merge(model_mem[lsu_cmd_addr], lsu_cmd_wdata, lsu_cmd_wmask);
      end
      if (gnt != 2'b00) m_last_ifu = gnt[0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] d5;
  int          pct;

  initial begin
    rst_n = 1'b0; ls_en = 1'b0;
    ifu_cmd_valid = 1'b0; ifu_cmd_addr = '0; ifu_rsp_ready = 1'b1;
    lsu_cmd_valid = 1'b0; lsu_cmd_read = 1'b1; lsu_cmd_addr = '0;
    lsu_cmd_wdata = '0; lsu_cmd_wmask = '0; lsu_rsp_ready = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      env_mem[i]   = {$urandom, $urandom};
      model_mem[i] = env_mem[i];
    end
    env_mem[16]   = 64'hDEADBEEF_00000001;
    model_mem[16] = 64'hDEADBEEF_00000001;
    d5 = model_mem[5];

    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("reset_ifu_ready", 64'(ifu_cmd_ready), 64'h0);
    chk("reset_lsu_ready", 64'(lsu_cmd_ready), 64'h0);
    chk("reset_ram_cs", 64'(ram_cs), 64'h0);

    // IFU single read
    tick(); ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h010; #1;
    chk("t1_ifu_ready", 64'(ifu_cmd_ready), 64'h1);
    chk("t1_ram_cs", 64'(ram_cs), 64'h1);
    chk("t1_ram_addr", 64'(ram_addr), 64'h10);
    tick(); ifu_cmd_valid = 1'b0; #1;
    chk("t1_rsp_valid", 64'(ifu_rsp_valid), 64'h1);
    chk("t1_rsp_rdata", ifu_rsp_rdata, 64'hDEADBEEF_00000001);

    // both ports contending: LSU, IFU, LSU, IFU
    for (int k = 0; k < 4; k++) begin
      tick();
      ifu_cmd_valid = 1'b1; ifu_cmd_addr = AW'(k + 1);
      lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = AW'(k + 8);
      #1;
      chk("t2_lsu_grant", 64'(lsu_cmd_ready), 64'(k % 2 == 0));
      chk("t2_ifu_grant", 64'(ifu_cmd_ready), 64'(k % 2 == 1));
      chk("t2_ram_cs", 64'(ram_cs), 64'h1);
    end

    // LSU partial write
    tick(); ifu_cmd_valid = 1'b0;
    lsu_cmd_read = 1'b0; lsu_cmd_addr = 13'h020;
    lsu_cmd_wdata = 64'h1122334455667788; lsu_cmd_wmask = 8'h0F; #1;
    chk("t3_ram_we", 64'(ram_we), 64'h1);
    chk("t3_ram_wem", 64'(ram_wem), 64'h0F);
    chk("t3_ram_din", ram_din, 64'h1122334455667788);
    tick(); lsu_cmd_valid = 1'b0; lsu_cmd_read = 1'b1; #1;
    chk("t3_rsp_valid", 64'(lsu_rsp_valid), 64'h1);
    chk("t3_rsp_rdata", lsu_rsp_rdata, 64'h0);

    // LSU response back-pressure with IFU traffic running alongside
    tick(); lsu_cmd_valid = 1'b1; lsu_cmd_addr = 13'd5; lsu_rsp_ready = 1'b0; #1;
    chk("t4_lsu_accept", 64'(lsu_cmd_ready), 64'h1);
    tick(); lsu_cmd_addr = 13'd6; ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'd7;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1;
      chk("t4_held_data", lsu_rsp_rdata, d5);
      chk("t4_lsu_blocked", 64'(lsu_cmd_ready), 64'h0);
      chk("t4_ifu_flows", 64'(ifu_cmd_ready), 64'h1);
    end
    tick(); lsu_rsp_ready = 1'b1; #1;
    chk("t4_release_data", lsu_rsp_rdata, d5);
    chk("t4_release_valid", 64'(lsu_rsp_valid), 64'h1);
    chk("t4_still_blocked", 64'(lsu_cmd_ready), 64'h0);
    tick(); #1;
    chk("t4_lsu_accept2", 64'(lsu_cmd_ready), 64'h1);

    // light sleep entry and wake
    tick(); ifu_cmd_valid = 1'b0; lsu_cmd_valid = 1'b0; ls_en = 1'b1;
    repeat (15) tick();
    #1; chk("t5_not_yet_ls", 64'(ram_ls), 64'h0);
    repeat (5) tick();
    #1;
    chk("t5_ram_ls", 64'(ram_ls), 64'h1);
    chk("t5_inactive", 64'(itcm_active), 64'h0);
    tick(); ifu_cmd_valid = 1'b1; ifu_cmd_addr = 13'h010; #1;
    chk("t5_sleep_ready", 64'(ifu_cmd_ready), 64'h0);
    tick(); #1;
    chk("t5_wake_ls", 64'(ram_ls), 64'h0);
    chk("t5_wake_ready", 64'(ifu_cmd_ready), 64'h0);
    chk("t5_wake_active", 64'(itcm_active), 64'h1);
    tick(); #1;
    chk("t5_active_grant", 64'(ifu_cmd_ready), 64'h1);
    tick(); ifu_cmd_valid = 1'b0; ls_en = 1'b0;

    // randomized traffic in phases of varying load
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 200 == 0) begin
        pct   = (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(10, 90)));
        ls_en = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 149) == 0) ls_en = ~ls_en;
      ifu_cmd_valid = ($urandom_range(0, 99) < pct);
      ifu_cmd_addr  = AW'($urandom_range(0, 31));
      ifu_rsp_ready = ($urandom_range(0, 3) != 0);
      lsu_cmd_valid = ($urandom_range(0, 99) < pct);
      lsu_cmd_read  = ($urandom_range(0, 1) == 1);
      lsu_cmd_addr  = AW'($urandom_range(0, 31));
      lsu_cmd_wdata = {$urandom, $urandom};
      lsu_cmd_wmask = MW'($urandom);
      lsu_rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // reset while an LSU response is held
    tick(); ifu_cmd_valid = 1'b0; lsu_cmd_valid = 1'b0; ls_en = 1'b0;
    ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    repeat (4) tick();
    lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 13'd3; lsu_rsp_ready = 1'b0; #1;
    chk("t6_accept", 64'(lsu_cmd_ready), 64'h1);
    tick(); lsu_cmd_valid = 1'b0;
    tick(); #1;
    chk("t6_held_valid", 64'(lsu_rsp_valid), 64'h1);
    #1; rst_n = 1'b0; #1;
    chk("t6_rst_lsu_valid", 64'(lsu_rsp_valid), 64'h0);
    chk("t6_rst_ifu_valid", 64'(ifu_rsp_valid), 64'h0);
    tick(); tick(); rst_n = 1'b1; lsu_rsp_ready = 1'b1; #1;
    chk("t6_post_valid", 64'(lsu_rsp_valid), 64'h0);
    tick(); #1;
    chk("t6_post_valid2", 64'(lsu_rsp_valid), 64'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
